// File: rtl/prbs18_checker.sv
// rtl/prbs18_checker.sv - self-synchronising PRBS18 (x^18+x^11+1) bit error checker
// Optional all-zero history detection: PRBS18_ZERO_DET_EN
module prbs18_checker #(
  parameter int LOCK_COUNT  = 32,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_CNT_W   = 16,
  parameter int BIT_CNT_W   = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 in_bit,
  input  logic                 in_valid,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [BIT_CNT_W-1:0] bit_count,
  output logic                 stuck_zero
);

  localparam logic [1:0] SEED   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

`ifdef PRBS18_ZERO_DET_EN
  localparam logic ZERO_DET = 1'b1;
`else
  localparam logic ZERO_DET = 1'b0;
`endif

  logic [1:0]        state, state_n;
  logic [18:1]       h, h_n;
  logic [4:0]        fill, fill_n;
  logic [RUN_W-1:0]  run, run_n;
  logic [5:0]        wpos, wpos_n;
  logic [WERR_W-1:0] werr, werr_n, werr_sum;
  logic              exp_bit, miss, pulse_n, err_inc, bit_inc;

  assign exp_bit  = h[11] ^ h[18];
  assign miss     = in_bit ^ exp_bit;
  assign werr_sum = werr + {{(WERR_W-1){1'b0}}, miss};

  always_comb begin
    state_n = state;
    h_n     = h;
    fill_n  = fill;
    run_n   = run;
    wpos_n  = wpos;
    werr_n  = werr;
    pulse_n = 1'b0;
    err_inc = 1'b0;
    bit_inc = 1'b0;
    if (in_valid) begin
      case (state)
        SEED: begin
          h_n    = {h[17:1], in_bit};
          fill_n = fill + 5'd1;
          if (fill == 5'd17) begin
            state_n = SEARCH;
            run_n   = '0;
          end
        end
        SEARCH: begin
          h_n = {h[17:1], in_bit};
          if (miss) begin
            run_n = '0;
          end else if (run == RUN_W'(LOCK_COUNT - 1)) begin
            run_n = '0;
            // an all-zero history predicts zeros forever; never trust it as lock
            if (!stuck_zero) begin
              state_n = LOCKED;
              wpos_n  = '0;
              werr_n  = '0;
            end
          end else begin
            run_n = run + RUN_W'(1);
          end
        end
        LOCKED: begin
          // free-running reference: a corrupted bit never pollutes the history
          h_n     = {h[17:1], exp_bit};
          bit_inc = 1'b1;
          err_inc = miss;
          pulse_n = miss;
          wpos_n  = wpos + 6'd1;
          if (werr_sum >= WERR_W'(LOSS_THRESH)) begin
            state_n = SEED;
            fill_n  = '0;
          end else if (wpos == 6'd63) begin
            werr_n = '0;
          end else begin
            werr_n = werr_sum;
          end
        end
        default: state_n = SEED;
      endcase
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= SEED;
      h          <= '0;
      fill       <= '0;
      run        <= '0;
      wpos       <= '0;
      werr       <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      bit_count  <= '0;
      stuck_zero <= 1'b0;
    end else begin
      state      <= state_n;
      h          <= h_n;
      fill       <= fill_n;
      run        <= run_n;
      wpos       <= wpos_n;
      werr       <= werr_n;
      locked     <= (state_n == LOCKED);
      err_pulse  <= pulse_n;
      stuck_zero <= ZERO_DET && (state_n != SEED) && (h_n == '0);
      if (clr_cnt)
        err_count <= '0;
      else if (err_inc && (err_count != {ERR_CNT_W{1'b1}}))
        err_count <= err_count + ERR_CNT_W'(1);
      if (clr_cnt)
        bit_count <= '0;
      else if (bit_inc && (bit_count != {BIT_CNT_W{1'b1}}))
        bit_count <= bit_count + BIT_CNT_W'(1);
    end
  end

endmodule

// File: doc/prbs18_checker.md
Name: prbs18_checker

Overview:
- Serial PRBS checker that receives the bit stream produced by the team's 18-bit Fibonacci LFSR generator (polynomial x^18 + x^11 + 1, period 262143).
- Self-synchronises to the incoming stream, declares lock, then counts bit errors against a free-running local reference.
- Sits at the receive end of the PRBS test link and feeds lock and error status to the link-test logic.

Parameters:
- LOCK_COUNT, 32: consecutive correctly predicted bits required in SEARCH before declaring lock.
- LOSS_THRESH, 8: errors within one 64-bit window, while LOCKED, that force loss of lock.
- ERR_CNT_W, 16: width of err_count.
- BIT_CNT_W, 32: width of bit_count.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-low reset.
- in_bit  in  1  received serial bit, sampled when in_valid=1.
- in_valid  in  1  sample qualifier; no state changes when 0.
- clr_cnt  in  1  synchronous clear of err_count and bit_count.
- locked  out  1  1 while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched sample while LOCKED.
- err_count  out  ERR_CNT_W  saturating count of errors seen while LOCKED.
- bit_count  out  BIT_CNT_W  saturating count of valid samples checked while LOCKED.
- stuck_zero  out  1  all-zero history flag (see Optional Feature).

Behaviour:
- History register h[18:1]: h[1] is the newest sample, h[18] the oldest. Each valid sample shifts h up by one place.
- Expected bit: exp = h[11] ^ h[18]. This matches the generator recurrence y[t] = y[t-11] ^ y[t-18].
- Reset (clear=0, asynchronous):
  - state=SEED, h=0, all counters=0.
  - locked=0, err_pulse=0, err_count=0, bit_count=0, stuck_zero=0.
- SEED:
  - Each valid sample shifts in_bit into h and increments the fill counter.
  - After the 18th valid sample, go to SEARCH with run=0.
  - No comparisons are made in SEED.
- SEARCH:
  - Each valid sample is compared with exp, then in_bit is shifted into h (self-synchronising).
  - Match: run increments. Mismatch: run clears to 0 and the state stays SEARCH.
  - When run reaches LOCK_COUNT, go to LOCKED. locked=1 from the cycle after that sample.
- LOCKED:
  - The predicted bit exp, not in_bit, is shifted into h. The reference runs free, so each corrupted bit counts as exactly one error.
  - Mismatch: err_pulse=1 in the next cycle, err_count+1, window error count+1.
  - Every valid sample: bit_count+1 and window position+1.
  - At the 64th valid sample of a window: window position and window error count reset to 0. A mismatch on that sample counts toward the old window and is checked against LOSS_THRESH first.
  - When window error count reaches LOSS_THRESH: go to SEED, fill counter=0, h keeps shifting in_bit from the next sample, locked=0 the next cycle.
  - err_count and bit_count hold their values on loss of lock.
- Counters:
  - err_count and bit_count saturate at all-ones and never wrap.
- clr_cnt:
  - Clears err_count and bit_count at the next edge in any state.
  - Wins over a simultaneous increment: the counter becomes 0. err_pulse still fires.
- in_valid=0: h, state, run, window and counters hold; err_pulse=0.
- All outputs are registered. Response latency is 1 cycle after the sampling edge.
- Reset asserted mid-operation: immediate return to the reset values above, regardless of state.

Optional Feature:
- Macro: PRBS18_ZERO_DET_EN.
- Defined:
  - stuck_zero=1 whenever h is all zeros in SEARCH or LOCKED. The all-zero state is the LFSR lock-up state and the stream carries no PRBS.
  - While stuck_zero=1, the transition SEARCH->LOCKED is blocked.
- Not defined: stuck_zero is tied to 0 and lock is unaffected.

Test Plan:
- Reset, then feed the generator stream seeded all-ones (first 18 bits =1) with in_valid=1 continuously -> locked rises 1 cycle after sample 18+32=50; err_count=0, bit_count counts from sample 51.
- Locked, flip one bit at sample 1000 -> exactly one err_pulse, err_count=1, locked stays 1.
- Locked, flip 8 bits within one 64-bit window -> locked=0 the cycle after the 8th error; relock at 50 further clean samples; err_count=8 held.
- Locked, flip 7 bits at window positions 60-63 and the next window's 0-2 -> no loss of lock (4+3 per window), err_count=7.
- Toggle in_valid 1/0 every cycle with a clean stream -> same lock point counted in valid samples (50); nothing changes on in_valid=0 cycles.
- clr_cnt asserted in the same cycle as an error -> err_count=0, err_pulse=1. With PRBS18_ZERO_DET_EN, an all-zero input -> stuck_zero=1 after 18 samples, locked never rises.
